// File: rtl/instruction_fetch_unit_pkg.sv
// Shared core definitions for the fetch front end: next-PC select codes,
// fetch FSM encodings, the reset NOP and an alignment helper.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JALR   = 2'b10,
    PC_SEL_RSVD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [63:0] PC_STEP  = 64'd4;

  // Only bit 1 matters: JALR targets have bit 0 cleared, branch offsets are even.
  function automatic logic target_misaligned(input logic [63:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_select.sv
// Combinational redirect decode: picks the control-transfer target, clears
// JALR bit 0 and classifies the redirect as effective or misaligned.
module next_pc_select
  import instruction_fetch_unit_pkg::*;
(
  input  logic        redirect_valid,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] branch_target,
  input  logic [63:0] jalr_target,
  output logic [63:0] target,
  output logic        effective,
  output logic        misaligned
);

  logic is_xfer_s;

  // Target mux and redirect classification
  always_comb begin
    target     = 64'd0;
    is_xfer_s  = 1'b0;
    effective  = 1'b0;
    misaligned = 1'b0;
    case (pc_sel_e'(pc_sel))
      PC_SEL_BRANCH: begin
        target    = branch_target;
        is_xfer_s = 1'b1;
      end
      PC_SEL_JALR: begin
        target    = {jalr_target[63:1], 1'b0};
        is_xfer_s = 1'b1;
      end
      default: begin
        target    = 64'd0;
        is_xfer_s = 1'b0;
      end
    endcase
    if (redirect_valid && is_xfer_s) begin
      misaligned = target_misaligned(target);
      effective  = !target_misaligned(target);
    end else begin
      misaligned = 1'b0;
      effective  = 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding-request instruction fetch unit: fetches one word,
// holds it for decode, and drains a stale request after a redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] branch_target,
  input  logic [63:0] jalr_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic [63:0] inst_pc_plus4,
  output logic        misaligned_fetch
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_addr_q, req_addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [63:0]  inst_pc_q, inst_pc_d;
  logic [63:0]  inst_pc_plus4_q, inst_pc_plus4_d;
  logic         inst_valid_q, inst_valid_d;
  logic         misaligned_q, misaligned_d;

  logic [63:0]  tgt_s;
  logic         eff_s;
  logic         mis_s;

  next_pc_select u_next_pc_select (
    .redirect_valid (redirect_valid),
    .pc_sel         (pc_sel),
    .branch_target  (branch_target),
    .jalr_target    (jalr_target),
    .target         (tgt_s),
    .effective      (eff_s),
    .misaligned     (mis_s)
  );

  // Next-state and datapath update for the fetch FSM
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_addr_d      = req_addr_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_pc_plus4_d = inst_pc_plus4_q;
    inst_valid_d    = inst_valid_q;
    misaligned_d    = mis_s;
    case (state_q)
      ST_FETCH: begin
        if (eff_s) begin
          pc_d = tgt_s;
          if (imem_ready) begin
            req_addr_d = tgt_s;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem_ready) begin
          inst_d          = imem_rdata;
          inst_pc_d       = req_addr_q;
          inst_pc_plus4_d = req_addr_q + PC_STEP;
          inst_valid_d    = 1'b1;
          state_d         = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (eff_s) begin
          pc_d         = tgt_s;
          req_addr_d   = tgt_s;
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (inst_ready) begin
          pc_d         = inst_pc_plus4_q;
          req_addr_d   = inst_pc_plus4_q;
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // A redirect landing in the completing cycle still wins over the older pc.
        if (eff_s) begin
          pc_d = tgt_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ready) begin
          req_addr_d = eff_s ? tgt_s : pc_q;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d      = ST_FETCH;
        req_addr_d   = pc_q;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_FETCH;
      pc_q            <= RESET_PC;
      req_addr_q      <= RESET_PC;
      inst_q          <= NOP_INST;
      inst_pc_q       <= RESET_PC;
      inst_pc_plus4_q <= RESET_PC + PC_STEP;
      inst_valid_q    <= 1'b0;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_addr_q      <= req_addr_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_pc_plus4_q <= inst_pc_plus4_d;
      inst_valid_q    <= inst_valid_d;
      misaligned_q    <= misaligned_d;
    end
  end

  assign imem_req         = (state_q != ST_HOLD);
  assign imem_addr        = req_addr_q;
  assign inst_valid       = inst_valid_q;
  assign inst             = inst_q;
  assign inst_pc          = inst_pc_q;
  assign inst_pc_plus4    = inst_pc_plus4_q;
  assign misaligned_fetch = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit; memory returns
// addr[31:0] | 0x8000_0000 so every captured word identifies its address.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [1:0]  pc_sel;
  logic [63:0] branch_target;
  logic [63:0] jalr_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] inst_pc_plus4;
  logic        misaligned_fetch;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr[31:0] | 32'h8000_0000;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .pc_sel           (pc_sel),
    .branch_target    (branch_target),
    .jalr_target      (jalr_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_pc_plus4    (inst_pc_plus4),
    .misaligned_fetch (misaligned_fetch)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [1:0]  sel;
    logic [63:0] bt;
    logic [63:0] jt;
    logic        rdy;
    logic        ird;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_v;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  function automatic vec_t mk(input logic r, input logic rv, input logic [1:0] sel,
                              input logic [63:0] bt, input logic [63:0] jt,
                              input logic rdy, input logic ird, input logic e_req,
                              input logic [63:0] e_addr, input logic e_v,
                              input logic [31:0] e_inst, input logic [63:0] e_ipc,
                              input logic e_mis);
    vec_t v;
    v.rst = r; v.rv = rv; v.sel = sel; v.bt = bt; v.jt = jt; v.rdy = rdy; v.ird = ird;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_inst = e_inst;
    v.e_ipc = e_ipc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic e_req, input logic [63:0] e_addr,
                       input logic e_v, input logic [31:0] e_inst, input logic [63:0] e_ipc,
                       input logic e_mis);
    logic [63:0] e_pc4;
    e_pc4 = e_ipc + 64'd4;
    n_vec++;
    if (imem_req !== e_req || imem_addr !== e_addr || inst_valid !== e_v ||
        inst !== e_inst || inst_pc !== e_ipc || inst_pc_plus4 !== e_pc4 ||
        misaligned_fetch !== e_mis) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h v=%b inst=%h pc=%h pc4=%h mis=%b want req=%b addr=%h v=%b inst=%h pc=%h pc4=%h mis=%b",
               name, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc_plus4,
               misaligned_fetch, e_req, e_addr, e_v, e_inst, e_ipc, e_pc4, e_mis);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; redirect_valid = v.rv; pc_sel = v.sel; branch_target = v.bt;
    jalr_target = v.jt; imem_ready = v.rdy; inst_ready = v.ird;
  endtask

  initial begin
    // sequential fetch, one instruction per two cycles
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 1,64'h400000,0,32'h00000013,64'h400000,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 0,64'h400000,1,32'h80400000,64'h400000,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 1,64'h400004,0,32'h80400000,64'h400000,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 0,64'h400004,1,32'h80400004,64'h400004,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 1,64'h400008,0,32'h80400004,64'h400004,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 0,64'h400008,1,32'h80400008,64'h400008,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 1,64'h40000C,0,32'h80400008,64'h400008,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 0,64'h40000C,1,32'h8040000C,64'h40000C,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 1,64'h400010,0,32'h8040000C,64'h40000C,0));
    // branch redirect from HOLD without inst_ready
    tbl.push_back(mk(0,1,2'b01,64'h400100,0,0,0, 0,64'h400010,1,32'h80400010,64'h400010,0));
    // misaligned branch in FETCH: one-cycle pulse, nothing else moves
    tbl.push_back(mk(0,1,2'b01,64'h400102,0,0,0, 1,64'h400100,0,32'h80400010,64'h400010,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0, 1,64'h400100,0,32'h80400010,64'h400010,1));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 1,64'h400100,0,32'h80400010,64'h400010,0));
    // stall in HOLD for 5 cycles, reserved pc_sel ignored
    tbl.push_back(mk(0,1,2'b11,64'h500000,64'h600000,1,0, 0,64'h400100,1,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,1,2'b11,64'h500000,64'h600000,1,0, 0,64'h400100,1,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 0,64'h400100,1,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 0,64'h400100,1,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 0,64'h400100,1,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,1, 0,64'h400100,1,32'h80400100,64'h400100,0));
    // redirect in FETCH with ready: data discarded, new request to 0x400020
    tbl.push_back(mk(0,1,2'b01,64'h400020,0,1,0, 1,64'h400104,0,32'h80400100,64'h400100,0));
    // JALR redirect with ready low -> DRAIN, address held for 3 stalled cycles
    tbl.push_back(mk(0,1,2'b10,0,64'h400201,0,0, 1,64'h400020,0,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0, 1,64'h400020,0,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0, 1,64'h400020,0,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 1,64'h400020,0,32'h80400100,64'h400100,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 1,64'h400200,0,32'h80400100,64'h400100,0));
    // branch to the top word, inst_pc_plus4 wraps to zero
    tbl.push_back(mk(0,1,2'b01,TOP,0,0,0, 0,64'h400200,1,32'h80400200,64'h400200,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 1,TOP,0,32'h80400200,64'h400200,0));
    tbl.push_back(mk(0,1,2'b10,0,64'h400000,0,0, 0,TOP,1,32'hFFFFFFFC,TOP,0));
    // two redirects during DRAIN: last one wins
    tbl.push_back(mk(0,1,2'b01,64'h400300,0,0,0, 1,64'h400000,0,32'hFFFFFFFC,TOP,0));
    tbl.push_back(mk(0,1,2'b10,0,64'h400401,0,0, 1,64'h400000,0,32'hFFFFFFFC,TOP,0));
    tbl.push_back(mk(0,0,2'b00,0,0,1,0, 1,64'h400000,0,32'hFFFFFFFC,TOP,0));
    // enter DRAIN, then reset overrides a concurrent redirect and ready
    tbl.push_back(mk(0,1,2'b01,64'h400500,0,0,0, 1,64'h400400,0,32'hFFFFFFFC,TOP,0));
    tbl.push_back(mk(1,1,2'b01,64'h400800,0,1,1, 1,64'h400400,0,32'hFFFFFFFC,TOP,0));
    // misaligned JALR after bit-0 clear
    tbl.push_back(mk(0,1,2'b10,0,64'h400006,0,0, 1,64'h400000,0,32'h00000013,64'h400000,0));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0, 1,64'h400000,0,32'h00000013,64'h400000,1));
    tbl.push_back(mk(0,0,2'b00,0,0,0,0, 1,64'h400000,0,32'h00000013,64'h400000,0));

    rst = 1'b1; redirect_valid = 1'b0; pc_sel = 2'b00; branch_target = 64'd0;
    jalr_target = 64'd0; imem_ready = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
            tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_mis);
      drive(tbl[i]);
    end

    // Long stall in FETCH: request address must not move
    imem_ready = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d", k), 1'b1, 64'h400000, 1'b0, 32'h00000013, 64'h400000, 1'b0);
    end
    imem_ready = 1'b1;
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      imem_ready = 1'b0;
      while (inst_valid !== 1'b1 && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      check("stall_release", 1'b0, 64'h400000, 1'b1, 32'h80400000, 64'h400000, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
